// File: rtl/sha256_round_core.sv
// Iterative SHA-256 compression core: one round per clock, a 16-word sliding
// message schedule and the final chaining addition. K is read from an external ROM.
module sha256_round_core (
  input  logic         clk,
  input  logic         rst,
  input  logic         init,
  input  logic         next,
  input  logic [511:0] block,
  output logic         ready,
  output logic [255:0] digest,
  output logic         digest_valid,
  output logic [5:0]   round,
  input  logic [31:0]  K
);

  typedef enum logic [1:0] {S_IDLE, S_ROUNDS, S_FINAL} state_t;

  localparam logic [255:0] IV = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  function automatic logic [31:0] big_sigma0(input logic [31:0] x);
    return {x[1:0], x[31:2]} ^ {x[12:0], x[31:13]} ^ {x[21:0], x[31:22]};
  endfunction

  function automatic logic [31:0] big_sigma1(input logic [31:0] x);
    return {x[5:0], x[31:6]} ^ {x[10:0], x[31:11]} ^ {x[24:0], x[31:25]};
  endfunction

  function automatic logic [31:0] small_sigma0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
  endfunction

  function automatic logic [31:0] small_sigma1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
  endfunction

  state_t       r_state;
  state_t       w_state_nxt;
  logic [5:0]   r_cnt;
  logic [31:0]  r_wv  [8];   // working registers a..h at index 0..7
  logic [31:0]  r_hin [8];   // chaining value captured at the accepting edge
  logic [31:0]  r_w   [16];  // message schedule window, r_w[0] is the current W
  logic [255:0] r_digest;
  logic         r_valid;

  logic         w_accept;
  logic [31:0]  w_load [8];
  logic [31:0]  w_t1;
  logic [31:0]  w_t2;
  logic [31:0]  w_wnew;

  assign w_accept = (r_state == S_IDLE) && (init || next);

  always_comb begin
    for (int i = 0; i < 8; i++) begin
      w_load[i] = init ? IV[255 - 32*i -: 32] : r_digest[255 - 32*i -: 32];
    end
  end

  assign w_t1 = r_wv[7] + big_sigma1(r_wv[4])
              + ((r_wv[4] & r_wv[5]) ^ (~r_wv[4] & r_wv[6])) + K + r_w[0];
  assign w_t2 = big_sigma0(r_wv[0])
              + ((r_wv[0] & r_wv[1]) ^ (r_wv[0] & r_wv[2]) ^ (r_wv[1] & r_wv[2]));
  assign w_wnew = small_sigma1(r_w[14]) + r_w[9] + small_sigma0(r_w[1]) + r_w[0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // NOTE: default assigned first so no path through the case leaves w_state_nxt unassigned (no latch).
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (w_accept) w_state_nxt = S_ROUNDS;
      S_ROUNDS: if (r_cnt == 6'd63) w_state_nxt = S_FINAL;
      S_FINAL:  w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // NOTE: the working and schedule arrays are reset explicitly so a reset mid-block leaves no stale data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt    <= '0;
      r_digest <= '0;
      r_valid  <= 1'b0;
      for (int i = 0; i < 8; i++) begin
        r_wv[i]  <= '0;
        r_hin[i] <= '0;
      end
      for (int i = 0; i < 16; i++) r_w[i] <= '0;
    end else if (w_accept) begin
      // NOTE: non-blocking assignments make every register update from pre-edge values.
      for (int i = 0; i < 8; i++) begin
        r_wv[i]  <= w_load[i];
        r_hin[i] <= w_load[i];
      end
      for (int i = 0; i < 16; i++) r_w[i] <= block[511 - 32*i -: 32];
      r_cnt   <= '0;
      r_valid <= 1'b0;
    end else if (r_state == S_ROUNDS) begin
      r_wv[0] <= w_t1 + w_t2;
      r_wv[1] <= r_wv[0];
      r_wv[2] <= r_wv[1];
      r_wv[3] <= r_wv[2];
      r_wv[4] <= r_wv[3] + w_t1;
      r_wv[5] <= r_wv[4];
      r_wv[6] <= r_wv[5];
      r_wv[7] <= r_wv[6];
      for (int i = 0; i < 15; i++) r_w[i] <= r_w[i+1];
      r_w[15] <= w_wnew;
      r_cnt   <= r_cnt + 6'd1;
    end else if (r_state == S_FINAL) begin
      for (int i = 0; i < 8; i++) r_digest[255 - 32*i -: 32] <= r_hin[i] + r_wv[i];
      r_valid <= 1'b1;
    end
  end

  assign ready        = (r_state == S_IDLE);
  assign digest       = r_digest;
  assign digest_valid = r_valid;
  assign round        = (r_state == S_ROUNDS) ? r_cnt : 6'd0;

endmodule
